matrix_display_fmt: RTL and testbench

- Parametrised successor to the single-slot display mode. It prints a user-selected stored matrix over UART.
- Output format: a "m x n" header, then each element as a right-aligned decimal field, optionally signed, with CR LF after every row.
- Sits between the mode controller, matrix manager slot query, BRAM read port and UART TX.
- Binary-to-decimal conversion is sequential (double-dabble), not combinational division.

---
 rtl/matrix_display_fmt.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_display_fmt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_display_fmt.sv
// Prints a stored matrix over UART: "m x n" header, then right-aligned decimal
// fields per element, CR LF after each row. Decimal conversion is double-dabble.
module matrix_display_fmt #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int SLOT_BITS     = 4,
  parameter int MAX_DIGITS    = 3,
  parameter int FIELD_WIDTH   = 4,
  parameter int SIGNED_ELEM   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode_active,
  input  logic                     start,
  input  logic [SLOT_BITS-1:0]     sel_slot,
  output logic [SLOT_BITS-1:0]     query_slot,
  input  logic                     query_valid,
  input  logic [3:0]               query_m,
  input  logic [3:0]               query_n,
  input  logic [ADDR_WIDTH-1:0]    query_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               error_code
);
  localparam int BW = 4 * MAX_DIGITS;
  localparam logic [7:0] FW = 8'(FIELD_WIDTH);
  localparam logic [7:0] CR = 8'h0D, LF = 8'h0A, SP = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE, S_QUERY, S_ERR, S_HDR, S_RD, S_CAP, S_CONV, S_FMT, S_ADV, S_FIN
  } state_e;

  state_e                   state_q;
  logic [7:0]               idx_q;
  logic [3:0]               m_q, n_q, row_q, col_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [BW-1:0]            bcd_q, bcd_adj;
  logic [ELEMENT_WIDTH-1:0] mag_q, cap_mag;
  logic                     neg_q, cap_neg;
  logic [SLOT_BITS-1:0]     qslot_q;
  logic [7:0]               tx_data_q;
  logic                     tx_start_q;
  logic [3:0]               err_q;

  logic [7:0] cur_byte, seq_len, mlen, nlen, ndig, len, pad, body, pos;
  logic [3:0] dig;
  logic       last_col, can_send;

  assign query_slot  = qslot_q;
  assign mem_rd_en   = (state_q == S_RD);
  assign mem_rd_addr = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign error_code  = err_q;

  // One byte in flight: the cycle after a send is always skipped, then busy must be low.
  assign can_send = !tx_busy && !tx_start_q;
  assign last_col = (col_q == n_q - 4'd1);

  // Magnitude of -2^(W-1) is 2^(W-1), which still fits W unsigned bits.
  assign cap_neg = (SIGNED_ELEM != 0) && mem_rd_data[ELEMENT_WIDTH-1];
  assign cap_mag = cap_neg ? (~mem_rd_data + 1'b1) : mem_rd_data;

  function automatic logic [7:0] dim_chr(input logic [3:0] d, input logic hi);
    return hi ? 8'h31 : 8'h30 + {4'd0, (d >= 4'd10) ? d - 4'd10 : d};
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    cur_byte = SP;
    seq_len  = 8'd1;
    mlen = (m_q >= 4'd10) ? 8'd2 : 8'd1;
    nlen = (n_q >= 4'd10) ? 8'd2 : 8'd1;
    ndig = 8'd1;
    for (int i = 1; i < MAX_DIGITS; i++)
      if (bcd_q[4*i +: 4] != 4'd0) ndig = 8'(i + 1);
    len  = ndig + {7'd0, neg_q};
    pad  = (FW > len) ? FW - len : 8'd0;
    body = pad + len;
    pos  = ndig - 8'd1 - (idx_q - pad - {7'd0, neg_q});
    dig  = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (pos == 8'(i)) dig = bcd_q[4*i +: 4];
    case (state_q)
      S_ERR: begin
        seq_len = 8'd3;
        case (idx_q)
          8'd0:    cur_byte = 8'h45;
          8'd1:    cur_byte = CR;
          default: cur_byte = LF;
        endcase
      end
      S_HDR: begin
        seq_len = mlen + nlen + 8'd5;
        if (idx_q < mlen)                     cur_byte = dim_chr(m_q, mlen == 8'd2 && idx_q == 8'd0);
        else if (idx_q < mlen + 8'd3)         cur_byte = (idx_q == mlen + 8'd1) ? 8'h78 : SP;
        else if (idx_q < mlen + 8'd3 + nlen)  cur_byte = dim_chr(n_q, nlen == 8'd2 && idx_q == mlen + 8'd3);
        else if (idx_q == mlen + 8'd3 + nlen) cur_byte = CR;
        else                                  cur_byte = LF;
      end
      S_FMT: begin
        seq_len = body + (last_col ? 8'd2 : 8'd1);
        if (idx_q < pad)                   cur_byte = SP;
        else if (neg_q && idx_q == pad)    cur_byte = 8'h2D;
        else if (idx_q < body)             cur_byte = 8'h30 + {4'd0, dig};
        else if (idx_q == body)            cur_byte = last_col ? CR : SP;
        else                               cur_byte = LF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; idx_q <= '0; m_q <= '0; n_q <= '0; row_q <= '0; col_q <= '0;
      addr_q <= '0; bcd_q <= '0; mag_q <= '0; neg_q <= 1'b0; qslot_q <= '0;
      tx_data_q <= '0; tx_start_q <= 1'b0; err_q <= '0;
    end else if (!mode_active) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start) begin
          qslot_q <= sel_slot;
          err_q   <= '0;
          idx_q   <= '0;
          state_q <= S_QUERY;
        end
        // Manager answers one cycle after query_slot changes; sample on the second cycle.
        S_QUERY: if (idx_q == 8'd0) idx_q <= 8'd1;
        else begin
          idx_q <= '0;
          if (!query_valid) begin
            err_q <= 4'd1; state_q <= S_ERR;
          end else if (query_m == 4'd0 || query_n == 4'd0) begin
            err_q <= 4'd2; state_q <= S_ERR;
          end else begin
            m_q <= query_m; n_q <= query_n; addr_q <= query_addr;
            row_q <= '0; col_q <= '0;
            state_q <= S_HDR;
          end
        end
        S_ERR, S_HDR, S_FMT: if (can_send) begin
          tx_data_q  <= cur_byte;
          tx_start_q <= 1'b1;
          if (idx_q == seq_len - 8'd1) begin
            idx_q   <= '0;
            state_q <= (state_q == S_ERR) ? S_FIN : (state_q == S_HDR) ? S_RD : S_ADV;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          neg_q   <= cap_neg;
          mag_q   <= cap_mag;
          bcd_q   <= '0;
          idx_q   <= '0;
          state_q <= S_CONV;
        end
        S_CONV: begin
          bcd_q <= {bcd_adj[BW-2:0], mag_q[ELEMENT_WIDTH-1]};
          mag_q <= mag_q << 1;
          if (idx_q == 8'(ELEMENT_WIDTH - 1)) begin
            idx_q <= '0; state_q <= S_FMT;
          end else begin
            idx_q <= idx_q + 8'd1;
          end
        end
        // Row-major storage: a running address equals base + row*n + col.
        S_ADV: begin
          addr_q <= addr_q + 1'b1;
          if (row_q == m_q - 4'd1 && last_col) state_q <= S_FIN;
          else begin
            if (last_col) begin col_q <= '0; row_q <= row_q + 4'd1; end
            else col_q <= col_q + 4'd1;
            state_q <= S_RD;
          end
        end
        S_FIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_display_fmt.sv
// Directed bench: an unsigned and a signed instance, each with manager, BRAM and UART models.
module tb_matrix_display_fmt;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode_active = 1'b0;
  logic hold_en = 1'b0;
  always #5 clk = ~clk;

  logic          start_v [2];
  logic [3:0]    sel     [2];
  logic [3:0]    qslot   [2];
  logic          qv      [2];
  logic [3:0]    qm      [2];
  logic [3:0]    qn      [2];
  logic [AW-1:0] qa      [2];
  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];
  logic [7:0]    rd_data [2];
  logic [7:0]    txd     [2];
  logic          txs     [2];
  logic          txb     [2];
  logic          bsy     [2];
  logic          dn      [2];
  logic [3:0]    ec      [2];
  logic [7:0]    bcnt    [2];
  logic [7:0]    hcnt    [2];

  logic [7:0]    mem [1024];
  logic          sv [16];
  logic [3:0]    sm [16];
  logic [3:0]    sn [16];
  logic [AW-1:0] sa [16];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    matrix_display_fmt #(.SIGNED_ELEM(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode_active(mode_active),
      .start(start_v[g]), .sel_slot(sel[g]), .query_slot(qslot[g]),
      .query_valid(qv[g]), .query_m(qm[g]), .query_n(qn[g]), .query_addr(qa[g]),
      .mem_rd_en(rd_en[g]), .mem_rd_addr(rd_addr[g]), .mem_rd_data(rd_data[g]),
      .tx_data(txd[g]), .tx_start(txs[g]), .tx_busy(txb[g]),
      .busy(bsy[g]), .done(dn[g]), .error_code(ec[g])
    );
    assign txb[g] = (bcnt[g] != 8'd0) || (hcnt[g] != 8'd0);
  end

  // Synchronous peripheral models: slot manager, BRAM, UART busy.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        qv[i] <= 1'b0; qm[i] <= '0; qn[i] <= '0; qa[i] <= '0;
        rd_data[i] <= '0; bcnt[i] <= '0; hcnt[i] <= '0;
      end else begin
        qv[i] <= sv[qslot[i]]; qm[i] <= sm[qslot[i]];
        qn[i] <= sn[qslot[i]]; qa[i] <= sa[qslot[i]];
        if (rd_en[i]) rd_data[i] <= mem[rd_addr[i]];
        if (txs[i]) bcnt[i] <= 8'd3;
        else if (bcnt[i] != 8'd0) bcnt[i] <= bcnt[i] - 8'd1;
        if (start_v[i] && hold_en) hcnt[i] <= 8'd50;
        else if (hcnt[i] != 8'd0) hcnt[i] <= hcnt[i] - 8'd1;
      end
    end
  end

  logic [7:0]    rxq   [$];
  logic [AW-1:0] addrq [$];
  int viol = 0;
  int done_cnt [2];
  int rd_cnt   [2];
  bit txp      [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (txs[i]) begin
        rxq.push_back(txd[i]);
        if (txp[i] || txb[i]) viol <= viol + 1;
      end
      txp[i] <= txs[i];
      if (dn[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (rd_en[i]) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (i == 0) addrq.push_back(rd_addr[i]);
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input string tag, input string s);
    int fd;
    fd = -1;
    chk({tag, "_len"}, rxq.size(), s.len());
    for (int i = 0; i < s.len() && i < rxq.size(); i++)
      if (fd < 0 && rxq[i] != s[i]) fd = i;
    chk({tag, "_firstdiff"}, fd, -1);
  endtask

  task automatic run(input int d, input logic [3:0] slot, input int budget);
    int dc0;
    dc0 = done_cnt[d];
    @(negedge clk); sel[d] = slot; start_v[d] = 1'b1;
    @(negedge clk); start_v[d] = 1'b0;
    chk("busy_after_start", bsy[d], 1);
    for (int c = 0; c < budget && done_cnt[d] == dc0; c++) @(negedge clk);
    repeat (12) @(negedge clk);
    chk("done_once", done_cnt[d] - dc0, 1);
    chk("idle_after", bsy[d], 0);
  endtask

  string t1_exp;
  string big_exp;
  int    nb, dcs, crlf;

  initial begin
    t1_exp = "2 x 3\015\012   0    5   42\015\012 100  255    7\015\012";
    for (int i = 0; i < 2; i++) begin start_v[i] = 1'b0; sel[i] = '0; end
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    for (int s = 0; s < 16; s++) begin sv[s] = 1'b0; sm[s] = '0; sn[s] = '0; sa[s] = '0; end
    sv[2] = 1'b1; sm[2] = 4'd2;  sn[2] = 4'd3;  sa[2] = 10'h200;
    mem[10'h200] = 8'd0;   mem[10'h201] = 8'd5;   mem[10'h202] = 8'd42;
    mem[10'h203] = 8'd100; mem[10'h204] = 8'd255; mem[10'h205] = 8'd7;
    sv[3] = 1'b1; sm[3] = 4'd1;  sn[3] = 4'd3;  sa[3] = 10'h210;
    mem[10'h210] = 8'h80;  mem[10'h211] = 8'hFF;  mem[10'h212] = 8'h7F;
    sv[6] = 1'b1; sm[6] = 4'd0;  sn[6] = 4'd3;  sa[6] = 10'h220;
    sv[7] = 1'b1; sm[7] = 4'd15; sn[7] = 4'd15; sa[7] = 10'h3F0;
    for (int k = 0; k < 225; k++) mem[(10'h3F0 + k) % 1024] = 8'(k);
    mode_active = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_tx_start", txs[0], 0);
    chk("rst_tx_data", txd[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_err", ec[0], 0);
    chk("rst_rd_en", rd_en[0], 0);
    chk("rst_qslot", qslot[0], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2x3 unsigned
    rxq.delete();
    run(0, 4'd2, 3000);
    expect_stream("t1", t1_exp);
    chk("t1_err", ec[0], 0);

    // 1x3 signed, including the most negative value
    rxq.delete();
    run(1, 4'd3, 3000);
    expect_stream("t2", "1 x 3\015\012-128   -1  127\015\012");

    // empty slot, then zero dimension
    rxq.delete(); nb = rd_cnt[0];
    run(0, 4'd5, 500);
    expect_stream("t3", "E\015\012");
    chk("t3_err", ec[0], 1);
    chk("t3_no_rd", rd_cnt[0] - nb, 0);
    rxq.delete();
    run(0, 4'd6, 500);
    expect_stream("t3b", "E\015\012");
    chk("t3b_err", ec[0], 2);

    // UART held busy after start
    rxq.delete(); nb = viol; hold_en = 1'b1;
    run(0, 4'd2, 4000);
    hold_en = 1'b0;
    expect_stream("t4", t1_exp);
    chk("t4_handshake", viol - nb, 0);

    // abort mid-row, then restart
    rxq.delete();
    @(negedge clk); sel[0] = 4'd2; start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    for (int c = 0; c < 2000 && rxq.size() < 12; c++) @(negedge clk);
    chk("t5_reached_row", rxq.size() >= 12, 1);
    mode_active = 1'b0;
    @(negedge clk);
    chk("t5_idle", bsy[0], 0);
    nb = rxq.size(); dcs = done_cnt[0];
    repeat (30) @(negedge clk);
    chk("t5_no_tx", rxq.size(), nb);
    chk("t5_no_done", done_cnt[0], dcs);
    mode_active = 1'b1;
    repeat (2) @(negedge clk);
    rxq.delete();
    run(0, 4'd2, 3000);
    expect_stream("t5_restart", t1_exp);

    // 15x15 with address wrap
    big_exp = "15 x 15\015\012";
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        big_exp = {big_exp, $sformatf("%4d", r * 15 + c), (c == 14) ? "\015\012" : " "};
    rxq.delete(); addrq.delete();
    run(0, 4'd7, 40000);
    expect_stream("t6", big_exp);
    chk("t6_nrd", addrq.size(), 225);
    if (addrq.size() > 16) begin
      chk("t6_addr15", addrq[15], 10'h3FF);
      chk("t6_addr16", addrq[16], 10'h000);
    end
    crlf = 0;
    for (int i = 0; i + 1 < rxq.size(); i++)
      if (rxq[i] == 8'h0D && rxq[i+1] == 8'h0A) crlf++;
    chk("t6_crlf", crlf, 16);
    chk("all_handshake", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
